// File: rtl/uart_wrapper.sv
// UART command front end: two received bytes assembled into a 16-bit command, one response byte transmitted.
// Latency: cmd_rdy one clock after the second byte's stop-bit sample; TX start bit the clock after send_resp.
// Backpressure: cmd held until clr_cmd_rdy (bytes in READY dropped); send_resp ignored while tx_busy. Option: UART_RX_TIMEOUT_EN.
module uart_wrapper #(
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] baud_cnt,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {A_HIGH, A_LOW, A_READY} asm_state_t;
  typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;

  // Short periods are clamped so the half-period start resample stays meaningful.
  logic [15:0] baud_eff;
  assign baud_eff = (baud_cnt < 16'd16) ? 16'd16 : baud_cnt;

  // ---------------- receiver ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        byte_vld_q, byte_vld_d;

  // Receiver next state: detect falling edge, resample mid start bit, then one full period per bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_per_d   = rx_per_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_vld_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_per_d   = baud_eff;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_per_q >> 1) - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_per_q - 16'd1) begin
          rx_cnt_d = 16'd0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_per_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          byte_vld_d = rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers, including the two-flop RX synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_per_q   <= 16'd16;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_per_q   <= rx_per_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  // ---------------- command assembler ----------------
  asm_state_t  asm_state_q, asm_state_d;
  logic [15:0] cmd_q, cmd_d;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TB_W = $clog2(TIMEOUT_BITS + 1);
  logic [15:0]     tmo_clk_q, tmo_clk_d;
  logic [TB_W-1:0] tmo_bit_q, tmo_bit_d;
  logic            tmo_hit;

  // Inter-byte timeout: counts bit periods in LOW while the receiver is idle.
  always_comb begin
    tmo_clk_d = 16'd0;
    tmo_bit_d = '0;
    tmo_hit   = 1'b0;
    if (asm_state_q == A_LOW && rx_state_q == RX_IDLE) begin
      tmo_clk_d = tmo_clk_q + 16'd1;
      tmo_bit_d = tmo_bit_q;
      if (tmo_clk_q == baud_eff - 16'd1) begin
        tmo_clk_d = 16'd0;
        if (tmo_bit_q == TB_W'(TIMEOUT_BITS - 1)) tmo_hit = 1'b1;
        else tmo_bit_d = tmo_bit_q + 1'b1;
      end
    end
  end

  // Timeout counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_clk_q <= 16'd0;
      tmo_bit_q <= '0;
    end else begin
      tmo_clk_q <= tmo_clk_d;
      tmo_bit_q <= tmo_bit_d;
    end
  end
`else
  logic tmo_hit;
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_BITS;
`endif

  // Assembler next state: high byte, low byte, then hold until the consumer clears.
  always_comb begin
    asm_state_d = asm_state_q;
    cmd_d       = cmd_q;
    case (asm_state_q)
      A_HIGH: begin
        if (byte_vld_q) begin
          cmd_d[15:8] = rx_sh_q;
          asm_state_d = A_LOW;
        end
      end
      A_LOW: begin
        if (byte_vld_q) begin
          cmd_d[7:0]  = rx_sh_q;
          asm_state_d = A_READY;
        end else if (tmo_hit) begin
          cmd_d[15:8] = 8'd0;
          asm_state_d = A_HIGH;
        end
      end
      A_READY: begin
        if (clr_cmd_rdy) asm_state_d = A_HIGH;
      end
      default: asm_state_d = A_HIGH;
    endcase
  end

  // Assembler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state_q <= A_HIGH;
      cmd_q       <= 16'd0;
    end else begin
      asm_state_q <= asm_state_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = (asm_state_q == A_READY);

  // ---------------- transmitter ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic        tx_q, tx_d;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_end;

  // Last clock of the stop bit (bit index 9 = stop).
  assign tx_end = (tx_state_q == TX_SHIFT) && (tx_bit_q == 4'd9) && (tx_cnt_q == tx_per_q - 16'd1);

  // Transmitter next state: start bit driven on acceptance, then one bit per latched period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_d       = tx_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_per_d   = tx_per_q;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = 16'd0;
        tx_d     = 1'b1;
        if (send_resp) begin
          tx_state_d = TX_SHIFT;
          tx_sh_d    = {1'b1, resp};
          tx_per_d   = baud_eff;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b0;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt_q == tx_per_q - 16'd1) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end else begin
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[8:1]};
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Transmitter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_sh_q    <= 9'd0;
      tx_cnt_q   <= 16'd0;
      tx_per_q   <= 16'd16;
      tx_bit_q   <= 4'd0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_per_q   <= tx_per_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = (tx_state_q == TX_SHIFT);
  assign resp_sent = tx_end;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed bench for uart_wrapper with baud_cnt = 16.
// Expected commands and TX bits are queued when stimulus is driven and compared when the DUT produces them.
// Summary line reports comparisons made and failures.
module tb_uart_wrapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] baud_cnt = 16'h0010;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] cmd_sb[$];
  logic        tx_sb[$];

  uart_wrapper #(.TIMEOUT_BITS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .baud_cnt    (baud_cnt),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic v);
    RX = v;
    repeat (16) step();
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
  endtask

  // Wait (bounded) for cmd_rdy, then compare cmd against the oldest queued command.
  task automatic expect_cmd(input string tag);
    int n;
    logic [15:0] exp;
    n = 0;
    while (!cmd_rdy && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, {15'd0, cmd_rdy}, 16'd1);
    exp = (cmd_sb.size() > 0) ? cmd_sb.pop_front() : 16'hxxxx;
    chk({tag, "_cmd"}, cmd, exp);
  endtask

  task automatic clear_cmd(input string tag);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk({tag, "_clr"}, {15'd0, cmd_rdy}, 16'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic exp_bit;
    logic [7:0] frame_byte;

    // Reset state
    repeat (3) step();
    chk("rst_tx", {15'd0, TX}, 16'd1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_busy", {15'd0, tx_busy}, 16'd0);
    chk("rst_sent", {15'd0, resp_sent}, 16'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // clr outside READY is ignored; basic two-byte command
    clear_cmd("idle_clr");
    cmd_sb.push_back(16'h4123);
    rx_byte(8'h41, 1'b1);
    rx_byte(8'h23, 1'b1);
    expect_cmd("basic");
    // A byte arriving in READY is dropped and cmd holds
    rx_byte(8'h55, 1'b1);
    repeat (4) step();
    chk("ready_hold_cmd", cmd, 16'h4123);
    chk("ready_hold_rdy", {15'd0, cmd_rdy}, 16'd1);
    clear_cmd("basic");

    // Framing error drops the second byte
    cmd_sb.push_back(16'h4177);
    rx_byte(8'h41, 1'b1);
    rx_byte(8'h23, 1'b0);
    rx_bit(1'b1);
    rx_byte(8'h77, 1'b1);
    expect_cmd("framing");
    clear_cmd("framing");

    // Start-bit glitch yields no byte
    RX = 1'b0;
    repeat (4) step();
    RX = 1'b1;
    repeat (40) step();
    chk("glitch_rdy", {15'd0, cmd_rdy}, 16'd0);
    cmd_sb.push_back(16'h1234);
    rx_byte(8'h12, 1'b1);
    rx_byte(8'h34, 1'b1);
    expect_cmd("glitch");
    clear_cmd("glitch");

    // Long gap after the first byte
`ifdef UART_RX_TIMEOUT_EN
    cmd_sb.push_back(16'h1234);
`else
    cmd_sb.push_back(16'h8012);
`endif
    rx_byte(8'h80, 1'b1);
    repeat (40 * 16) step();
    rx_byte(8'h12, 1'b1);
    rx_byte(8'h34, 1'b1);
    expect_cmd("gap");
    clear_cmd("gap");

    // Transmit 0xA5, second send_resp mid-frame ignored, resp changed after acceptance
    frame_byte = 8'hA5;
    tx_sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_sb.push_back(frame_byte[i]);
    tx_sb.push_back(1'b1);
    resp = 8'hA5;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    resp = 8'h3C;
    chk("tx_busy_start", {15'd0, tx_busy}, 16'd1);
    for (int k = 1; k <= 161; k++) begin
      if ((k % 16) == 8) begin
        exp_bit = (tx_sb.size() > 0) ? tx_sb.pop_front() : 1'bx;
        chk($sformatf("tx_bit%0d", k / 16), {15'd0, TX}, {15'd0, exp_bit});
      end
      if (k == 159) chk("tx_sent_early", {15'd0, resp_sent}, 16'd0);
      if (k == 160) chk("tx_sent", {15'd0, resp_sent}, 16'd1);
      if (k == 160) chk("tx_busy_last", {15'd0, tx_busy}, 16'd1);
      if (k == 161) begin
        chk("tx_idle", {15'd0, TX}, 16'd1);
        chk("tx_busy_end", {15'd0, tx_busy}, 16'd0);
      end
      send_resp = (k == 50);
      if (k < 161) step();
    end
    send_resp = 1'b0;

    // baud_cnt below 16 is clamped: frame still 160 clocks
    baud_cnt = 16'd4;
    resp = 8'h5A;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    baud_cnt = 16'h0010;
    cyc = 1;
    while (!resp_sent && cyc < 400) begin
      step();
      cyc++;
    end
    chk("clamp_len", cyc[15:0], 16'd160);
    repeat (4) step();

    // Reset at clock 70 of a frame aborts it
    resp = 8'h0F;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    repeat (69) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx", {15'd0, TX}, 16'd1);
    chk("mid_rst_busy", {15'd0, tx_busy}, 16'd0);
    chk("mid_rst_sent", {15'd0, resp_sent}, 16'd0);
    chk("mid_rst_cmd", cmd, 16'h0000);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      if (resp_sent) pulses++;
      step();
    end
    chk("mid_rst_nopulse", pulses[15:0], 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
